// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared types and constants for the data-memory arbiter.
package dm_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int ID_W   = 1;

  localparam logic [BE_W-1:0] BE_FULL = 4'b1111;
  localparam logic [BE_W-1:0] BE_NONE = 4'b0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_CAP,
    S_RMW_RD,
    S_MERGE,
    S_ACK
  } state_t;

endpackage

// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - requester ports m0/m1 plus the single data-memory port.
interface dm_arbiter_if #(parameter int AW = 10);
  import dm_pkg::*;

  logic              m0_req;
  logic              m0_we;
  logic [BE_W-1:0]   m0_be;
  logic [31:0]       m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [BE_W-1:0]   m1_be;
  logic [31:0]       m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  logic [AW-1:0]     dm_addr;
  logic [DATA_W-1:0] dm_din;
  logic              dm_we;
  logic [DATA_W-1:0] dm_dout;
  logic              busy;

  modport slave (
    input  m0_req, m0_we, m0_be, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_be, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    output dm_addr, dm_din, dm_we, busy,
    input  dm_dout
  );

  modport master (
    output m0_req, m0_we, m0_be, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_be, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    input  dm_addr, dm_din, dm_we, busy,
    output dm_dout
  );

endinterface

// File: rtl/dm_lane_merge.sv
// rtl/dm_lane_merge.sv - byte-lane merge of the old memory word with new store data.
module dm_lane_merge
  import dm_pkg::*;
(
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_word,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port load/store arbiter for the word-wide data memory,
// with read-modify-write for partial byte-enable stores.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int AW   = 10,
  parameter bit FAIR = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  dm_arbiter_if.slave  bus
);

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic              id_q, id_d;
  logic              we_q, we_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              win;
  logic              sel_we;
  logic [BE_W-1:0]   sel_be;
  logic [AW-1:0]     sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] merged;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.m0_addr[1:0], bus.m0_addr[31:AW+2],
                              bus.m1_addr[1:0], bus.m1_addr[31:AW+2]};

  dm_lane_merge u_merge (
    .old_word (bus.dm_dout),
    .new_word (wdata_q),
    .be       (be_q),
    .merged   (merged)
  );

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    id_d     = id_q;
    we_d     = we_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    // prio_q names the port that wins a tie; a lone requester always wins.
    if (bus.m0_req && bus.m1_req) win = FAIR ? prio_q : 1'b0;
    else                          win = bus.m1_req;

    sel_we    = win ? bus.m1_we    : bus.m0_we;
    sel_be    = win ? bus.m1_be    : bus.m0_be;
    sel_addr  = win ? bus.m1_addr[AW+1:2] : bus.m0_addr[AW+1:2];
    sel_wdata = win ? bus.m1_wdata : bus.m0_wdata;

    case (state_q)
      S_IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          id_d    = win;
          prio_d  = ~win;
          we_d    = sel_we;
          be_d    = sel_be;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          if (!sel_we)                 state_d = S_RD;
          else if (sel_be == BE_FULL)  state_d = S_WR;
          else if (sel_be == BE_NONE)  state_d = S_ACK;
          else                         state_d = S_RMW_RD;
        end
      end
      S_WR:     state_d = S_ACK;
      S_RD:     state_d = S_CAP;
      S_CAP: begin
        if (id_q) rdata1_d = bus.dm_dout;
        else      rdata0_d = bus.dm_dout;
        state_d = S_ACK;
      end
      S_RMW_RD: state_d = S_MERGE;
      S_MERGE:  state_d = S_ACK;
      S_ACK:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      prio_q   <= 1'b0;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      id_q     <= id_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Reset gates the write strobe so a reset in WR/MERGE cannot corrupt memory.
  assign bus.dm_we    = (state_q == S_WR || state_q == S_MERGE) && !rst;
  assign bus.dm_din   = (state_q == S_MERGE) ? merged : wdata_q;
  assign bus.dm_addr  = addr_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.m0_ack   = (state_q == S_ACK) && !id_q;
  assign bus.m1_ack   = (state_q == S_ACK) &&  id_q;
  assign bus.m0_rdata = rdata0_q;
  assign bus.m1_rdata = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - self-checking bench for dm_arbiter, fair and fixed-priority builds.
module tb_dm_arbiter;
  import dm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dm_arbiter_if #(.AW(10)) if_f ();
  dm_arbiter_if #(.AW(10)) if_p ();

  dm_arbiter #(.AW(10), .FAIR(1'b1)) dut_f (.clk(clk), .rst(rst), .bus(if_f.slave));
  dm_arbiter #(.AW(10), .FAIR(1'b0)) dut_p (.clk(clk), .rst(rst), .bus(if_p.slave));

  logic [31:0] mem_f [1024];
  logic [31:0] mem_p [1024];
  always @(posedge clk) begin
    if (if_f.dm_we) mem_f[if_f.dm_addr] <= if_f.dm_din;
    if_f.dm_dout <= mem_f[if_f.dm_addr];
    if (if_p.dm_we) mem_p[if_p.dm_addr] <= if_p.dm_din;
    if_p.dm_dout <= mem_p[if_p.dm_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_f [1024];
  logic        we_log   [8];
  logic [9:0]  addr_log [8];
  logic [31:0] din_log  [8];

  function automatic logic [31:0] ref_merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] be);
    logic [31:0] r;
    logic [31:0] mask;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      mask = 32'hFF << (8 * i);
      if (be[i]) r = (r & ~mask) | (new_w & mask);
    end
    return r;
  endfunction

  function automatic int exp_lat(logic we, logic [3:0] be);
    if (!we) return 3;
    if (be == 4'hF) return 2;
    if (be == 4'h0) return 1;
    return 3;
  endfunction

  // Issues one request on the fair DUT; called and returns just after a rising edge.
  task automatic do_req(input bit port, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output bit oth);
    logic ack, oack;
    for (int i = 0; i < 8; i++) we_log[i] = 1'b0;
    if (port) begin
      if_f.m1_we = we; if_f.m1_be = be; if_f.m1_addr = addr; if_f.m1_wdata = wdata; if_f.m1_req = 1'b1;
    end else begin
      if_f.m0_we = we; if_f.m0_be = be; if_f.m0_addr = addr; if_f.m0_wdata = wdata; if_f.m0_req = 1'b1;
    end
    lat = -1; oth = 1'b0; rdata = 32'h0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (n < 8) begin
        we_log[n] = if_f.dm_we; addr_log[n] = if_f.dm_addr; din_log[n] = if_f.dm_din;
      end
      ack  = port ? if_f.m1_ack : if_f.m0_ack;
      oack = port ? if_f.m0_ack : if_f.m1_ack;
      if (oack) oth = 1'b1;
      if (ack) begin
        lat = n;
        rdata = port ? if_f.m1_rdata : if_f.m0_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    if (port) if_f.m1_req = 1'b0; else if_f.m0_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (if_f.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_f: got %b want 0", if_f.busy); end
    n_tests++; if (if_p.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_p: got %b want 0", if_p.busy); end
    n_tests++; if ({if_f.m0_ack, if_f.m1_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b want 00", {if_f.m0_ack, if_f.m1_ack}); end
    n_tests++; if (if_f.m0_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata0: got %h want 0", if_f.m0_rdata); end
    n_tests++; if (if_f.m1_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata1: got %h want 0", if_f.m1_rdata); end
    n_tests++; if (if_f.dm_we !== 1'b0) begin n_fail++; $display("FAIL reset_dm_we: got %b want 0", if_f.dm_we); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_full_write();
    int lat; logic [31:0] rd; bit oth;
    do_req(1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, rd, oth);
    ref_f[4] = 32'hDEADBEEF;
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL fw_latency: got %0d want 2", lat); end
    n_tests++; if (we_log[0] !== 1'b0 || we_log[1] !== 1'b1) begin n_fail++; $display("FAIL fw_dm_we: got %b%b want 01", we_log[0], we_log[1]); end
    n_tests++; if (addr_log[1] !== 10'd4) begin n_fail++; $display("FAIL fw_dm_addr: got %0d want 4", addr_log[1]); end
    n_tests++; if (din_log[1] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fw_dm_din: got %h want deadbeef", din_log[1]); end
    n_tests++; if (oth) begin n_fail++; $display("FAIL fw_other_ack: got 1 want 0"); end
    do_req(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, lat, rd, oth);
    n_tests++; if (lat != 3) begin n_fail++; $display("FAIL rd_latency: got %0d want 3", lat); end
    n_tests++; if (rd !== ref_f[4]) begin n_fail++; $display("FAIL rd_data: got %h want %h", rd, ref_f[4]); end
  endtask

  task automatic test_partial_write();
    int lat; logic [31:0] rd; bit oth; logic [31:0] exp;
    exp = ref_merge(ref_f[4], 32'h00005500, 4'b0010);
    ref_f[4] = exp;
    do_req(1'b1, 1'b1, 4'b0010, 32'h10, 32'h00005500, lat, rd, oth);
    n_tests++; if (lat != 3) begin n_fail++; $display("FAIL pw_latency: got %0d want 3", lat); end
    n_tests++; if (we_log[1] !== 1'b0 || we_log[2] !== 1'b1) begin n_fail++; $display("FAIL pw_dm_we: got %b%b want 01", we_log[1], we_log[2]); end
    n_tests++; if (din_log[2] !== exp) begin n_fail++; $display("FAIL pw_dm_din: got %h want %h", din_log[2], exp); end
    do_req(1'b1, 1'b0, 4'h0, 32'h1010, 32'h0, lat, rd, oth);
    n_tests++; if (rd !== 32'hDEAD55EF) begin n_fail++; $display("FAIL pw_alias_read: got %h want dead55ef", rd); end
    n_tests++; if (oth) begin n_fail++; $display("FAIL pw_other_ack: got 1 want 0"); end
  endtask

  task automatic test_be_none();
    int lat; logic [31:0] rd; bit oth;
    do_req(1'b0, 1'b1, 4'h0, 32'h10, 32'h12345678, lat, rd, oth);
    n_tests++; if (lat != 1) begin n_fail++; $display("FAIL be0_latency: got %0d want 1", lat); end
    n_tests++; if (we_log[0] !== 1'b0 || we_log[1] !== 1'b0) begin n_fail++; $display("FAIL be0_dm_we: got %b%b want 00", we_log[0], we_log[1]); end
    do_req(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, lat, rd, oth);
    n_tests++; if (rd !== ref_f[4]) begin n_fail++; $display("FAIL be0_mem: got %h want %h", rd, ref_f[4]); end
  endtask

  task automatic test_reset_in_merge();
    int lat; logic [31:0] rd; bit oth;
    if_f.m0_we = 1'b1; if_f.m0_be = 4'b0100; if_f.m0_addr = 32'h10; if_f.m0_wdata = 32'hAABBCCDD;
    if_f.m0_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (if_f.busy !== 1'b1) begin n_fail++; $display("FAIL rim_busy_rmw: got %b want 1", if_f.busy); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (if_f.dm_we !== 1'b0) begin n_fail++; $display("FAIL rim_dm_we: got %b want 0", if_f.dm_we); end
    n_tests++; if (if_f.m0_ack !== 1'b0) begin n_fail++; $display("FAIL rim_ack_merge: got %b want 0", if_f.m0_ack); end
    @(posedge clk); #1;
    rst = 1'b0;
    if_f.m0_req = 1'b0;
    @(negedge clk);
    n_tests++; if (if_f.busy !== 1'b0) begin n_fail++; $display("FAIL rim_busy_after: got %b want 0", if_f.busy); end
    n_tests++; if (if_f.m0_ack !== 1'b0) begin n_fail++; $display("FAIL rim_ack_after: got %b want 0", if_f.m0_ack); end
    @(posedge clk); #1;
    do_req(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, lat, rd, oth);
    n_tests++; if (rd !== ref_f[4]) begin n_fail++; $display("FAIL rim_mem: got %h want %h", rd, ref_f[4]); end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd; bit oth;
    bit port, we; logic [3:0] be; int word; logic [31:0] addr, data;
    for (int w = 8; w < 16; w++) begin
      data = $urandom;
      ref_f[w] = data;
      do_req(1'($urandom_range(0, 1)), 1'b1, 4'hF, 32'(w) << 2, data, lat, rd, oth);
    end
    for (int k = 0; k < 40; k++) begin
      port = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      be   = 4'($urandom_range(0, 15));
      word = $urandom_range(8, 15);
      addr = ($urandom & 32'hFFFF_F000) | (32'(word) << 2) | 32'($urandom_range(0, 3));
      data = $urandom;
      do_req(port, we, be, addr, data, lat, rd, oth);
      n_tests++; if (lat != exp_lat(we, be)) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", k, lat, exp_lat(we, be)); end
      n_tests++; if (oth) begin n_fail++; $display("FAIL rand_other_ack[%0d]: got 1 want 0", k); end
      if (!we) begin
        n_tests++; if (rd !== ref_f[word]) begin n_fail++; $display("FAIL rand_rdata[%0d]: got %h want %h", k, rd, ref_f[word]); end
      end else begin
        ref_f[word] = ref_merge(ref_f[word], data, be);
      end
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_round_robin();
    int acks; bit exp_id; bit id; logic [31:0] exp_rd [2];
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    if_f.m0_we = 1'b0; if_f.m0_addr = 32'h20; if_f.m0_req = 1'b1;
    if_f.m1_we = 1'b0; if_f.m1_addr = 32'h24; if_f.m1_req = 1'b1;
    acks = 0; exp_id = 1'b0;
    for (int n = 0; n < 60 && acks < 6; n++) begin
      @(negedge clk);
      if (if_f.m0_ack && if_f.m1_ack) begin
        n_tests++; n_fail++; $display("FAIL rr_both_ack: got 11 want one-hot");
      end else if (if_f.m0_ack || if_f.m1_ack) begin
        id = if_f.m1_ack;
        n_tests++; if (id != exp_id) begin n_fail++; $display("FAIL rr_grant[%0d]: got m%0d want m%0d", acks, id, exp_id); end
        exp_rd[id] = ref_f[8 + int'(id)];
        n_tests++; if ((id ? if_f.m1_rdata : if_f.m0_rdata) !== exp_rd[id]) begin n_fail++; $display("FAIL rr_rdata[%0d]: got %h want %h", acks, id ? if_f.m1_rdata : if_f.m0_rdata, exp_rd[id]); end
        n_tests++; if ((id ? if_f.m0_rdata : if_f.m1_rdata) !== exp_rd[!id]) begin n_fail++; $display("FAIL rr_other_rdata[%0d]: got %h want %h", acks, id ? if_f.m0_rdata : if_f.m1_rdata, exp_rd[!id]); end
        exp_id = ~exp_id;
        acks++;
      end
    end
    n_tests++; if (acks != 6) begin n_fail++; $display("FAIL rr_ack_count: got %0d want 6", acks); end
    @(posedge clk); #1;
    if_f.m0_req = 1'b0; if_f.m1_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fixed_priority();
    int a0, a1, lat; logic [31:0] v;
    v = $urandom;
    if_p.m1_we = 1'b1; if_p.m1_be = 4'hF; if_p.m1_addr = 32'h14; if_p.m1_wdata = v; if_p.m1_req = 1'b1;
    lat = -1;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (if_p.m1_ack) begin lat = n; break; end
    end
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL fp_setup_latency: got %0d want 2", lat); end
    @(posedge clk); #1;
    if_p.m1_we = 1'b0;
    if_p.m0_we = 1'b0; if_p.m0_addr = 32'h14; if_p.m0_req = 1'b1;
    a0 = 0; a1 = 0;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      if (if_p.m0_ack) a0++;
      if (if_p.m1_ack) a1++;
    end
    n_tests++; if (a1 != 0) begin n_fail++; $display("FAIL fp_m1_starved: got %0d acks want 0", a1); end
    n_tests++; if (a0 != 6) begin n_fail++; $display("FAIL fp_m0_acks: got %0d want 6", a0); end
    n_tests++; if (if_p.m0_rdata !== v) begin n_fail++; $display("FAIL fp_m0_rdata: got %h want %h", if_p.m0_rdata, v); end
    @(posedge clk); #1;
    if_p.m0_req = 1'b0;
    lat = -1;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (if_p.m1_ack) begin lat = n; break; end
    end
    n_tests++; if (lat != 3) begin n_fail++; $display("FAIL fp_m1_after_drop: got %0d want 3", lat); end
    n_tests++; if (if_p.m1_rdata !== v) begin n_fail++; $display("FAIL fp_m1_rdata: got %h want %h", if_p.m1_rdata, v); end
    @(posedge clk); #1;
    if_p.m1_req = 1'b0;
  endtask

  initial begin
    if_f.m0_req = 1'b0; if_f.m0_we = 1'b0; if_f.m0_be = 4'h0; if_f.m0_addr = 32'h0; if_f.m0_wdata = 32'h0;
    if_f.m1_req = 1'b0; if_f.m1_we = 1'b0; if_f.m1_be = 4'h0; if_f.m1_addr = 32'h0; if_f.m1_wdata = 32'h0;
    if_p.m0_req = 1'b0; if_p.m0_we = 1'b0; if_p.m0_be = 4'h0; if_p.m0_addr = 32'h0; if_p.m0_wdata = 32'h0;
    if_p.m1_req = 1'b0; if_p.m1_we = 1'b0; if_p.m1_be = 4'h0; if_p.m1_addr = 32'h0; if_p.m1_wdata = 32'h0;
    test_reset();
    test_full_write();
    test_partial_write();
    test_be_none();
    test_reset_in_merge();
    test_random();
    test_round_robin();
    test_fixed_priority();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
